cr_fifo_wrap2: RTL
==================

CR_FIFO_WRAP2 -- requirements
Module: cr_fifo_wrap2

Interface
REQ-001 SHALL have parameter N_DATA_BITS, default 64, width of each data word.
REQ-002 SHALL have parameter N_ENTRIES, default 8, FIFO depth (0 = combinational pass-through; any value >= 1 legal, not restricted to powers of 2).
REQ-003 SHALL have parameter N_AFULL_VAL, default 1, reset value of the almost-full threshold.
REQ-004 SHALL have parameter N_AEMPTY_VAL, default 1, reset value of the almost-empty threshold.
REQ-005 SHALL define CW = clog2(N_ENTRIES+1) as the width of all count and threshold ports.
REQ-006 SHALL have ports:
  - clk  in  1  sole clock; one clock; all state on rising edge.
  - rst_n  in  1  reset, asynchronous assert, active-low.
  - wdata  in  N_DATA_BITS  write data.
  - wen  in  1  write request.
  - ren  in  1  read request.
  - afull_thresh  in  CW  runtime almost-full threshold.
  - aempty_thresh  in  CW  runtime almost-empty threshold.
  - thresh_ld  in  1  loads both thresholds into internal registers.
  - clr_stat  in  1  clears sticky errors and high-watermark.
  - rdata  out  N_DATA_BITS  head-of-FIFO word (show-ahead).
  - full, empty, afull, aempty  out  1 each  status flags.
  - free_slots, used_slots  out  CW each  occupancy.
  - hwm  out  CW  peak used_slots since reset/clear.
  - overflow, underflow  out  1 each  sticky error flags.

Function
REQ-007 SHALL store words in a register array with rd_ptr/wr_ptr, each wrapping from N_ENTRIES-1 to 0.
REQ-008 SHALL accept a write iff wen && !full, regardless of ren; no write-through when full.
REQ-009 SHALL accept a read iff ren && !empty, regardless of wen; no bypass when empty.
REQ-010 SHALL update used_slots next cycle: +1 write only, -1 read only, unchanged if both or neither accepted.
REQ-011 SHALL drive free_slots = N_ENTRIES - used_slots, full = (used_slots == N_ENTRIES), empty = (used_slots == 0), all from registered state.
REQ-012 SHALL drive rdata = entry at rd_ptr, valid whenever !empty, with zero read latency; write-to-visible latency 1 cycle.
REQ-013 SHALL capture afull_thresh/aempty_thresh into internal threshold registers on the cycle thresh_ld=1; thresholds hold otherwise.
REQ-014 SHALL drive afull = (free_slots <= afull threshold register) and aempty = (used_slots <= aempty threshold register), unsigned compare.
REQ-015 SHALL set overflow on any cycle with wen && full, and underflow on any cycle with ren && empty; both stay set until clr_stat or reset.
REQ-016 SHALL update hwm to max(hwm, next used_slots) every cycle.
REQ-017 SHALL on clr_stat clear overflow, underflow to 0 and load hwm with the current used_slots; an error event in the same cycle wins (flag set).
REQ-018 SHALL leave stored data and pointers unaffected by thresh_ld and clr_stat.
REQ-019 SHALL, when N_ENTRIES == 0, tie full=0, afull=0, empty=1, aempty=1, free_slots=used_slots=hwm=0, overflow=underflow=0, rdata=wdata, and instantiate no storage.

Reset
REQ-020 SHALL on rst_n low asynchronously force pointers=0, used_slots=0, hwm=0, overflow=underflow=0, thresholds=N_AFULL_VAL/N_AEMPTY_VAL; outputs then show empty=1, full=0, free_slots=N_ENTRIES.
REQ-021 SHALL discard all stored words on reset mid-operation; storage array contents need not be reset, and rdata is don't-care while empty.

Verification (N_DATA_BITS=8, N_ENTRIES=5, N_AFULL_VAL=1, N_AEMPTY_VAL=1)
REQ-022 SHALL cover fill/drain: write 0x11..0x55 -> full=1, afull=1, free_slots=0, hwm=5; read 5 -> rdata 0x11..0x55 in order, empty=1.
REQ-023 SHALL cover wrap and simultaneous access: hold 3 entries, wen&ren for 10 cycles -> used_slots stays 3, data in order across pointer wrap at 4->0.
REQ-024 SHALL cover errors: wen at full -> word dropped, overflow=1; ren at empty -> underflow=1; clr_stat -> both 0, hwm=used_slots.
REQ-025 SHALL cover thresholds: thresh_ld with afull_thresh=3, aempty_thresh=2 -> afull rises at used_slots=2, aempty falls at used_slots=3.
REQ-026 SHALL cover reset mid-operation: 4 entries, overflow=1, rst_n pulse -> empty=1, overflow=0, hwm=0, thresholds back to 1/1.
REQ-027 SHALL cover N_ENTRIES=0 build: rdata tracks wdata same cycle, empty=1, full=0 constant.

Source files
------------

// File: rtl/cr_fifo_wrap2_if.sv
// Write/read handshake, threshold control and status bundle for cr_fifo_wrap2.
// CW is clamped to 1 bit for the zero-depth build so every port keeps a legal width.
interface cr_fifo_wrap2_if #(
  parameter int unsigned N_DATA_BITS = 64,
  parameter int unsigned N_ENTRIES   = 8
);
  localparam int unsigned CW = (N_ENTRIES == 0) ? 1 : $clog2(N_ENTRIES + 1);

  logic [N_DATA_BITS-1:0] wdata;
  logic                   wen;
  logic                   ren;
  logic [CW-1:0]          afull_thresh;
  logic [CW-1:0]          aempty_thresh;
  logic                   thresh_ld;
  logic                   clr_stat;
  logic [N_DATA_BITS-1:0] rdata;
  logic                   full;
  logic                   empty;
  logic                   afull;
  logic                   aempty;
  logic [CW-1:0]          free_slots;
  logic [CW-1:0]          used_slots;
  logic [CW-1:0]          hwm;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output wdata, wen, ren, afull_thresh, aempty_thresh, thresh_ld, clr_stat,
    input  rdata, full, empty, afull, aempty, free_slots, used_slots, hwm, overflow, underflow
  );

  modport slave (
    input  wdata, wen, ren, afull_thresh, aempty_thresh, thresh_ld, clr_stat,
    output rdata, full, empty, afull, aempty, free_slots, used_slots, hwm, overflow, underflow
  );
endinterface

// File: rtl/cr_fifo_wrap2.sv
// Show-ahead register FIFO with runtime almost-full/empty thresholds, sticky error flags
// and a high-watermark; depth 0 degenerates to a combinational pass-through.
module cr_fifo_wrap2 #(
  parameter int unsigned N_DATA_BITS  = 64,
  parameter int unsigned N_ENTRIES    = 8,
  parameter int unsigned N_AFULL_VAL  = 1,
  parameter int unsigned N_AEMPTY_VAL = 1
) (
  input logic            clk,
  input logic            rst_n,
  cr_fifo_wrap2_if.slave bus
);
  localparam int unsigned CW = (N_ENTRIES == 0) ? 1 : $clog2(N_ENTRIES + 1);

  if (N_ENTRIES == 0) begin : g_pass
    assign bus.rdata      = bus.wdata;
    assign bus.full       = 1'b0;
    assign bus.afull      = 1'b0;
    assign bus.empty      = 1'b1;
    assign bus.aempty     = 1'b1;
    assign bus.free_slots = '0;
    assign bus.used_slots = '0;
    assign bus.hwm        = '0;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
  end else begin : g_fifo
    localparam int unsigned PW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam logic [CW-1:0] Depth   = CW'(N_ENTRIES);
    localparam logic [PW-1:0] LastPtr = PW'(N_ENTRIES - 1);

    logic [N_DATA_BITS-1:0] mem_q [N_ENTRIES];
    logic [PW-1:0]          rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]          used_q, used_d;
    logic [CW-1:0]          hwm_q, hwm_d, hwm_base;
    logic [CW-1:0]          afull_th_q, aempty_th_q;
    logic                   ovf_q, udf_q;
    logic                   full_s, empty_s, wr_acc, rd_acc;

    always_comb begin
      full_s   = (used_q == Depth);
      empty_s  = (used_q == '0);
      wr_acc   = bus.wen && !full_s;
      rd_acc   = bus.ren && !empty_s;
      used_d   = used_q;
      if (wr_acc && !rd_acc) begin
        used_d = used_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        used_d = used_q - CW'(1);
      end
      // A clear restarts the watermark from the present occupancy, then tracks as usual.
      hwm_base = bus.clr_stat ? used_q : hwm_q;
      hwm_d    = (used_d > hwm_base) ? used_d : hwm_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr_q    <= '0;
        wr_ptr_q    <= '0;
        used_q      <= '0;
        hwm_q       <= '0;
        ovf_q       <= 1'b0;
        udf_q       <= 1'b0;
        afull_th_q  <= CW'(N_AFULL_VAL);
        aempty_th_q <= CW'(N_AEMPTY_VAL);
      end else begin
        if (wr_acc) begin
          wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
          rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
        end
        used_q <= used_d;
        hwm_q  <= hwm_d;
        // Error events in the same cycle as a clear keep the flag set.
        ovf_q  <= (bus.wen && full_s) || (ovf_q && !bus.clr_stat);
        udf_q  <= (bus.ren && empty_s) || (udf_q && !bus.clr_stat);
        if (bus.thresh_ld) begin
          afull_th_q  <= bus.afull_thresh;
          aempty_th_q <= bus.aempty_thresh;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (wr_acc) begin
        mem_q[wr_ptr_q] <= bus.wdata;
      end
    end

    assign bus.rdata      = mem_q[rd_ptr_q];
    assign bus.full       = full_s;
    assign bus.empty      = empty_s;
    assign bus.free_slots = Depth - used_q;
    assign bus.used_slots = used_q;
    assign bus.afull      = ((Depth - used_q) <= afull_th_q);
    assign bus.aempty     = (used_q <= aempty_th_q);
    assign bus.hwm        = hwm_q;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = udf_q;
  end
endmodule
